// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding a single UART transmitter: grants one requester in IDLE,
// then shifts out start, LSB-first data, optional parity and stop bits on a registered tx.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_TYPE  = 2,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          frame_done
);

    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int MAX_BITS = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic                    tx_q, tx_d;
    logic                    frame_done_q, frame_done_d;

    logic                    win_any_s;
    logic [ID_W-1:0]         win_idx_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic                    tick_s;
    int                      scan_idx_s;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
        if (PARITY_TYPE == 1) begin
            return ~^d;
        end else begin
            return ^d;
        end
    endfunction

    assign tick_s     = (baud_q == BAUD_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;

    // Round-robin scan from the pointer upward; lowest offset with a request wins.
    always_comb begin
        win_any_s  = 1'b0;
        win_idx_s  = '0;
        win_data_s = '0;
        scan_idx_s = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx_s = (int'(ptr_q) + k) % NUM_REQ;
            win_any_s  = req_valid[scan_idx_s] ? 1'b1 : win_any_s;
            win_idx_s  = req_valid[scan_idx_s] ? ID_W'(scan_idx_s) : win_idx_s;
            win_data_s = req_valid[scan_idx_s] ? req_data[scan_idx_s*DATA_WIDTH +: DATA_WIDTH]
                                               : win_data_s;
        end
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            ptr_q        <= '0;
            grant_q      <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            data_q       <= data_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: frame sequencing driven by the baud terminal count.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (win_any_s) begin
                    state_d = S_START;
                    data_d  = win_data_s;
                    grant_d = win_idx_s;
                    ptr_d   = (win_idx_s == ID_LAST) ? '0 : win_idx_s + ID_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs: tx and frame_done are precomputed from next-state so they land registered.
    always_comb begin
        req_ready    = '0;
        tx_d         = 1'b1;
        frame_done_d = 1'b0;
        if ((state_q == S_IDLE) && win_any_s && !rst) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = parity_bit(data_d);
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        frame_done_d = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based frame model with per-cycle compare, a mid-bit
// sampling receiver, and directed frame-shape checks on three parameterisations.
module tb_uart_tx_sched;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults. B: 5 data bits, odd parity, 2 stops. C: no parity.
    logic [3:0]  va;  logic [31:0] da; logic [3:0] rdy_a;
    logic        tx_a, busy_a, fd_a;   logic [1:0] gid_a;
    logic [1:0]  vb;  logic [9:0]  db; logic [1:0] rdy_b;
    logic        tx_b, busy_b, fd_b;   logic [0:0] gid_b;
    logic [1:0]  vc;  logic [15:0] dc; logic [1:0] rdy_c;
    logic        tx_c, busy_c, fd_c;   logic [0:0] gid_c;

    logic [2:0] tx_v, busy_v, fd_v;
    assign tx_v   = {tx_c, tx_b, tx_a};
    assign busy_v = {busy_c, busy_b, busy_a};
    assign fd_v   = {fd_c, fd_b, fd_a};

    uart_tx_sched u_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_data(da), .req_ready(rdy_a),
        .tx(tx_a), .busy(busy_a), .grant_id(gid_a), .frame_done(fd_a)
    );

    uart_tx_sched #(.NUM_REQ(2), .DATA_WIDTH(5), .PARITY_TYPE(1), .STOP_BITS(2),
                    .CLKS_PER_BIT(CPB)) u_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_data(db), .req_ready(rdy_b),
        .tx(tx_b), .busy(busy_b), .grant_id(gid_b), .frame_done(fd_b)
    );

    uart_tx_sched #(.NUM_REQ(2), .DATA_WIDTH(8), .PARITY_TYPE(0), .STOP_BITS(1),
                    .CLKS_PER_BIT(CPB)) u_c (
        .clk(clk), .rst(rst), .req_valid(vc), .req_data(dc), .req_ready(rdy_c),
        .tx(tx_c), .busy(busy_c), .grant_id(gid_c), .frame_done(fd_c)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, required event never seen (t=%0t)", name, $time);
    endtask

    // Behavioural model of instance A: a queue of per-cycle tx levels for the current frame.
    bit         mq[$];
    logic [7:0] sent_q[$];
    int         m_ptr = 0;
    int         m_grant = 0;
    bit         m_acc = 1'b0;
    int         m_acc_idx = 0;
    bit         rnd_en = 1'b0;

    function automatic int rr_winner(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        if (rst || mq.size() != 0) return 4'd0;
        w = rr_winner(va, m_ptr);
        if (w < 0) return 4'd0;
        return 4'd1 << w;
    endfunction

    task automatic push_bit(input bit b);
        for (int i = 0; i < CPB; i++) mq.push_back(b);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                sent_q.delete();
                m_ptr   = 0;
                m_grant = 0;
                m_acc   = 1'b0;
            end else begin
                m_acc = 1'b0;
                if (mq.size() > 0) begin
                    void'(mq.pop_front());
                end else begin
                    int w;
                    logic [7:0] d;
                    w = rr_winner(va, m_ptr);
                    if (w >= 0) begin
                        d = da[w*8 +: 8];
                        push_bit(1'b0);
                        for (int b = 0; b < 8; b++) push_bit(d[b]);
                        push_bit(^d);
                        push_bit(1'b1);
                        m_grant   = w;
                        m_ptr     = (w + 1) % 4;
                        m_acc     = 1'b1;
                        m_acc_idx = w;
                        sent_q.push_back(d);
                    end
                end
            end
        end
    end

    // Per-cycle compare of instance A against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("tx",         32'(tx_a),   (mq.size() != 0) ? 32'(mq[0]) : 32'd1);
            check("busy",       32'(busy_a), 32'(mq.size() != 0));
            check("frame_done", 32'(fd_a),   32'(mq.size() == 1));
            check("grant_id",   32'(gid_a),  32'(m_grant));
            check("req_ready",  32'(rdy_a),  32'(exp_ready()));
        end
    end

    // Requesters: drop after acceptance; in random mode raise new requests that hold until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (m_acc) va[m_acc_idx] = 1'b0;
            if (rnd_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (!va[i] && $urandom_range(15) == 0) begin
                        da[i*8 +: 8] = 8'($urandom_range(255));
                        va[i]        = 1'b1;
                    end
                end
            end
        end
    end

    // Receiver on instance A: samples each bit in its middle and checks against bytes sent.
    initial begin
        int t;
        int k;
        bit act;
        logic [7:0] rd;
        logic [7:0] exp_b;
        act = 1'b0;
        t   = 0;
        rd  = 8'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx_a == 1'b0) begin
                    act = 1'b1;
                    t   = 0;
                end
            end else begin
                t++;
                if (t % CPB == CPB / 2) begin
                    k = t / CPB;
                    if (k == 0) begin
                        check("rx_start", 32'(tx_a), 32'd0);
                    end else if (k <= 8) begin
                        rd[k-1] = tx_a;
                    end else if (k == 9) begin
                        check("rx_parity", 32'(tx_a), 32'(^rd));
                    end else begin
                        check("rx_stop", 32'(tx_a), 32'd1);
                        if (sent_q.size() == 0) begin
                            fail_timeout("rx_unexpected_frame");
                        end else begin
                            exp_b = sent_q.pop_front();
                            check("rx_data", 32'(rd), 32'(exp_b));
                        end
                        act = 1'b0;
                    end
                end
            end
        end
    end

    // Directed frame-shape measurement on one instance: bit levels, length, frame_done cycle.
    task automatic measure(input int inst, input int exp_len, input logic [15:0] exp_bits,
                           input int nbits);
        int n;
        int c;
        int fd_at;
        n = 0;
        while (!busy_v[inst] && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!busy_v[inst]) begin
            fail_timeout($sformatf("inst%0d_frame_start", inst));
            return;
        end
        case (inst)
            0:       va[0] = 1'b0;
            1:       vb[0] = 1'b0;
            default: vc[0] = 1'b0;
        endcase
        c     = 1;
        fd_at = 0;
        while (busy_v[inst] && c < 400) begin
            if (fd_v[inst] && fd_at == 0) fd_at = c;
            if (c % CPB == CPB / 2 && c / CPB < nbits)
                check($sformatf("inst%0d_bit%0d", inst, c / CPB), 32'(tx_v[inst]),
                      32'(exp_bits[c / CPB]));
            if (inst == 2 && c == 9 * CPB + 1)
                check("inst2_tx_after_data", 32'(tx_v[inst]), 32'd1);
            @(negedge clk);
            #1;
            c++;
        end
        check($sformatf("inst%0d_frame_len", inst), 32'(c - 1), 32'(exp_len));
        check($sformatf("inst%0d_frame_done_at", inst), 32'(fd_at), 32'(exp_len));
    endtask

    task automatic expect_grant(input int id, input int gap);
        int n;
        int g;
        n = 0;
        g = 0;
        while (busy_a && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        while (!busy_a && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
            g++;
        end
        if (!busy_a) begin
            fail_timeout($sformatf("grant_%0d", id));
            return;
        end
        check($sformatf("grant_id_%0d", id), 32'(gid_a), 32'(id));
        check("start_bit", 32'(tx_a), 32'd0);
        if (gap >= 0) check("idle_gap", 32'(g), 32'(gap));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_a && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy_a) fail_timeout("wait_idle");
    endtask

    initial begin
        int n;
        va = 4'd0; da = 32'd0; vb = 2'd0; db = 10'd0; vc = 2'd0; dc = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx",         32'(tx_a),  32'd1);
        check("reset_busy",       32'(busy_a), 32'd0);
        check("reset_req_ready",  32'(rdy_a), 32'd0);
        check("reset_grant_id",   32'(gid_a), 32'd0);
        check("reset_frame_done", 32'(fd_a),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single frames: A sends 0xA5, B sends 0x00, C sends 0xFF.
        @(negedge clk);
        va[0] = 1'b1; da[7:0] = 8'hA5;
        vb[0] = 1'b1; db[4:0] = 5'h00;
        vc[0] = 1'b1; dc[7:0] = 8'hFF;
        fork
            measure(0, 11 * CPB, 16'h054A, 11);
            measure(1,  9 * CPB, 16'h01C0,  9);
            measure(2, 10 * CPB, 16'h03FE, 10);
        join
        wait_idle();

        // All four requesting from reset: strict 0,1,2,3 with one idle cycle between frames.
        @(negedge clk);
        rst = 1'b1;
        va  = 4'hF;
        da  = {8'h3C, 8'hC3, 8'h5A, 8'h81};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_grant(0, -1);
        expect_grant(1, 1);
        expect_grant(2, 1);
        expect_grant(3, 1);
        wait_idle();

        // Pointer moves past the granted requester: after 2, prefer 3 over 1.
        @(negedge clk);
        da[23:16] = 8'h2E;
        va[2]     = 1'b1;
        expect_grant(2, -1);
        da[15:8]  = 8'h71; va[1] = 1'b1;
        da[31:24] = 8'hD4; va[3] = 1'b1;
        expect_grant(3, 1);
        expect_grant(1, 1);
        wait_idle();

        // Reset in the middle of data bit 3; held request is regranted from a fresh start bit.
        @(negedge clk);
        da[7:0] = 8'h96;
        va[0]   = 1'b1;
        expect_grant(0, -1);
        repeat (70) @(negedge clk);
        #3;
        rst   = 1'b1;
        va[0] = 1'b1;
        #1;
        check("midrst_tx",         32'(tx_a),  32'd1);
        check("midrst_busy",       32'(busy_a), 32'd0);
        check("midrst_req_ready",  32'(rdy_a), 32'd0);
        check("midrst_frame_done", 32'(fd_a),  32'd0);
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        expect_grant(0, -1);
        wait_idle();

        // Random traffic from all four requesters.
        rnd_en = 1'b1;
        repeat (15000) @(negedge clk);
        rnd_en = 1'b0;
        n = 0;
        while ((va != 4'd0 || busy_a) && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (va != 4'd0 || busy_a) fail_timeout("drain");
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit line between `NUM_REQ` requesters. It arbitrates among pending byte requests and accepts one word through a valid/ready handshake. It then serializes that word as a complete frame: start bit, data bits LSB first, optional parity, and stop bits. The block sits between on-chip producers and the UART `tx` pin, and its frame format matches the UART VIP used on the bench.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: data bits per frame, 5..8.
- `PARITY_TYPE`, 2: 0 = no parity bit, 1 = odd (`~^data`), 2 = even (`^data`).
- `STOP_BITS`, 1: 1 or 2.
- `CLKS_PER_BIT`, 16: `clk` cycles per bit period, ≥ 2.

Ports:
- `clk`, in, 1: single clock. Everything is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, `NUM_REQ`: per-requester request.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: requester i uses slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`, out, `NUM_REQ`: one-hot accept. A transfer occurs on the edge where `req_valid[i] && req_ready[i]`.
- `tx`, out, 1: serial line, registered, idle high.
- `busy`, out, 1: high while a frame is being shifted out.
- `grant_id`, out, `$clog2(NUM_REQ)`: index of the last accepted requester.
- `frame_done`, out, 1: one-cycle pulse on the last cycle of the final stop bit.

## Operation

- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: if any `req_valid` is high, `req_ready` is driven high for exactly one winner. This is combinational from `req_valid` and the priority pointer, and is valid only in IDLE. On that edge the block latches the data, sets `grant_id`, moves the pointer to winner+1 mod `NUM_REQ`, and goes to START.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: `DATA_WIDTH` bit periods, LSB first, driven from the latched word. Then PARITY if `PARITY_TYPE`≠0, else STOP.
  - PARITY: one bit period. The parity bit is computed from the latched word.
  - STOP: `tx`=1 for `STOP_BITS` bit periods, then IDLE.
- Round-robin arbitration: search starts at the pointer and wraps upward. The pointer resets to 0, so requester 0 has top priority after reset.
- Requester rule: once `req_valid[i]` is asserted, valid and data stay stable until accepted. Requests that are not granted wait with no limit. Starvation-free.
- Counters:
  - Baud counter `0..CLKS_PER_BIT-1`, `$clog2(CLKS_PER_BIT)` bits. It wraps at terminal count, which advances the bit.
  - Bit index counter `0..max(DATA_WIDTH, STOP_BITS)-1`.
- `busy` = state≠IDLE.
- No `req_ready` is asserted while busy. Input changes during a frame do not affect `tx`.

## Timing

- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `frame_done`=0, pointer=0, state=IDLE.
- Reset mid-frame: outputs take their reset values immediately (asynchronous). The latched word is discarded and the frame is aborted, not resumed. The interrupted requester's data must still be held valid, and it is regranted after reset release.
- Accept on edge E. `tx` falls at E+1 (registered) and `busy` rises at E+1.
- Frame length L = (1 + `DATA_WIDTH` + (`PARITY_TYPE`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles, covering cycles E+1..E+L.
- `frame_done` is high in cycle E+L. State is IDLE at E+L+1, and a new accept can occur on that edge.
- Minimum inter-frame idle gap is 1 cycle of `tx`=1 beyond the stop bits.
- Simultaneous requests are resolved in one cycle. There is no extra arbitration latency.

## Test plan

- Single frame, defaults, requester 0 sends 0xA5:
  - `tx` reads low ×16, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each held 16 cycles.
  - L=176, `frame_done` at E+176, `grant_id`=0.
- All four `req_valid` high from reset, each with a distinct byte: grants occur in order 0,1,2,3, frames are back-to-back with a 1-cycle gap, and each VIP `recv_data` matches.
- Pointer after a grant to requester 2, with only requesters 1 and 3 valid: 3 is granted first, then 1.
- `DATA_WIDTH`=5, `PARITY_TYPE`=1, `STOP_BITS`=2, data 0x00: frame is 9 bits, parity bit is 1, L=9×16=144.
- `PARITY_TYPE`=0, data 0xFF: no parity bit, L=10×16=160, and `tx` is high immediately after the last data bit.
- `rst` pulsed during DATA bit 3:
  - `tx`=1 and `busy`=0 in the same cycle.
  - After release, the held requester 0 is regranted and its full frame is sent from the start bit.
